// File: rtl/fcw_sweep_ctrl.sv
// Linear frequency-control-word sweep generator feeding the NCO fcw_input.
// Steps from a latched start word to a stop word, holding each word for a programmable dwell.
module fcw_sweep_ctrl #(
    parameter int unsigned FCW_W   = 32,
    parameter int unsigned DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               loop_en,
    input  logic [FCW_W-1:0]   fcw_start,
    input  logic [FCW_W-1:0]   fcw_stop,
    input  logic [FCW_W-1:0]   fcw_step,
    input  logic [DWELL_W-1:0] dwell,
    output logic [FCW_W-1:0]   fcw_out,
    output logic               fcw_valid,
    output logic               busy,
    output logic               step_tick,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, DWELL, DONE} state_t;

    state_t             state, state_n;
    logic [DWELL_W-1:0] cnt, cnt_n;
    logic [DWELL_W-1:0] reload_q, reload_n;
    logic [FCW_W-1:0]   start_q, start_n;
    logic [FCW_W-1:0]   stop_q, stop_n;
    logic [FCW_W-1:0]   step_q, step_n;
    logic               loop_q, loop_n;
    logic               dir_up_q, dir_up_n;
    logic [FCW_W-1:0]   fcw_n;
    logic               valid_n, busy_n, tick_n, done_n;
    logic [FCW_W-1:0]   next_word;
    logic [FCW_W:0]     sum, diff;

    // One extra bit catches overflow/borrow so the word clamps to stop instead of wrapping.
    always_comb begin
        sum  = {1'b0, fcw_out} + {1'b0, step_q};
        diff = {1'b0, fcw_out} - {1'b0, step_q};
        if (step_q == '0) begin
            next_word = stop_q;
        end else if (dir_up_q) begin
            next_word = (sum >= {1'b0, stop_q}) ? stop_q : sum[FCW_W-1:0];
        end else begin
            next_word = (diff[FCW_W] || (diff <= {1'b0, stop_q})) ? stop_q : diff[FCW_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            reload_q  <= '0;
            start_q   <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            loop_q    <= 1'b0;
            dir_up_q  <= 1'b0;
            fcw_out   <= '0;
            fcw_valid <= 1'b0;
            busy      <= 1'b0;
            step_tick <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            reload_q  <= reload_n;
            start_q   <= start_n;
            stop_q    <= stop_n;
            step_q    <= step_n;
            loop_q    <= loop_n;
            dir_up_q  <= dir_up_n;
            fcw_out   <= fcw_n;
            fcw_valid <= valid_n;
            busy      <= busy_n;
            step_tick <= tick_n;
            done      <= done_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        reload_n = reload_q;
        start_n  = start_q;
        stop_n   = stop_q;
        step_n   = step_q;
        loop_n   = loop_q;
        dir_up_n = dir_up_q;
        fcw_n    = fcw_out;
        valid_n  = fcw_valid;
        busy_n   = busy;
        tick_n   = 1'b0;
        done_n   = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) begin
                    start_n  = fcw_start;
                    stop_n   = fcw_stop;
                    step_n   = fcw_step;
                    loop_n   = loop_en;
                    dir_up_n = (fcw_stop >= fcw_start);
                    reload_n = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                    cnt_n    = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
                    fcw_n    = fcw_start;
                    valid_n  = 1'b1;
                    busy_n   = 1'b1;
                    tick_n   = 1'b1;
                    state_n  = DWELL;
                end
            end
            DWELL: begin
                if (abort) begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end else if (cnt != '0) begin
                    cnt_n = cnt - DWELL_W'(1);
                end else if (fcw_out == stop_q) begin
                    if (loop_q) begin
                        fcw_n  = start_q;
                        tick_n = 1'b1;
                        cnt_n  = reload_q;
                    end else begin
                        done_n  = 1'b1;
                        state_n = DONE;
                    end
                end else begin
                    fcw_n  = next_word;
                    tick_n = 1'b1;
                    cnt_n  = reload_q;
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_fcw_sweep_ctrl.sv
// Directed bench for fcw_sweep_ctrl: table of sweeps checked cycle by cycle,
// plus hand-written loop/abort and asynchronous-reset sequences.
module tb_fcw_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, abort, loop_en;
    logic [31:0] fcw_start, fcw_stop, fcw_step;
    logic [23:0] dwell;
    logic [31:0] fcw_out;
    logic        fcw_valid, busy, step_tick, done;

    int unsigned tests  = 0;
    int unsigned failed = 0;

    always #5 clk = ~clk;

    fcw_sweep_ctrl #(.FCW_W(32), .DWELL_W(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .loop_en   (loop_en),
        .fcw_start (fcw_start),
        .fcw_stop  (fcw_stop),
        .fcw_step  (fcw_step),
        .dwell     (dwell),
        .fcw_out   (fcw_out),
        .fcw_valid (fcw_valid),
        .busy      (busy),
        .step_tick (step_tick),
        .done      (done)
    );

    typedef struct {
        logic [31:0]       s;
        logic [31:0]       e;
        logic [31:0]       st;
        logic [23:0]       dw;
        logic              lp;
        int unsigned       n;
        int unsigned       d;
        logic [3:0][31:0]  w;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive_cfg(input vec_t v);
        fcw_start = v.s;
        fcw_stop  = v.e;
        fcw_step  = v.st;
        dwell     = v.dw;
        loop_en   = v.lp;
    endtask

    // Starts a sweep and checks every cycle from the start edge to return to IDLE.
    task automatic run_sweep(input int unsigned idx);
        vec_t v;
        v = vecs[idx];
        drive_cfg(v);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        fcw_start = 32'hDEAD_BEEF;
        fcw_stop  = 32'h0;
        for (int unsigned c = 0; c < v.n * v.d + 2; c++) begin
            if (c < v.n * v.d) begin
                chk($sformatf("v%0d c%0d fcw_out", idx, c), fcw_out, v.w[c / v.d]);
                chk($sformatf("v%0d c%0d step_tick", idx, c), {31'b0, step_tick}, {31'b0, (c % v.d) == 0});
                chk($sformatf("v%0d c%0d busy", idx, c), {31'b0, busy}, 32'd1);
                chk($sformatf("v%0d c%0d done", idx, c), {31'b0, done}, 32'd0);
            end else begin
                chk($sformatf("v%0d c%0d hold", idx, c), fcw_out, v.w[v.n - 1]);
                chk($sformatf("v%0d c%0d done", idx, c), {31'b0, done}, {31'b0, c == v.n * v.d});
                chk($sformatf("v%0d c%0d busy", idx, c), {31'b0, busy}, {31'b0, c == v.n * v.d});
                chk($sformatf("v%0d c%0d step_tick", idx, c), {31'b0, step_tick}, 32'd0);
            end
            chk($sformatf("v%0d c%0d valid", idx, c), {31'b0, fcw_valid}, 32'd1);
            @(negedge clk);
        end
    endtask

    initial begin
        vecs[0] = '{s:32'd100, e:32'd130, st:32'd10, dw:24'd4, lp:1'b0, n:4, d:4,
                    w:{32'd130, 32'd120, 32'd110, 32'd100}};
        vecs[1] = '{s:32'd1000, e:32'd975, st:32'd10, dw:24'd0, lp:1'b0, n:4, d:1,
                    w:{32'd975, 32'd980, 32'd990, 32'd1000}};
        vecs[2] = '{s:32'hFFFF_FFF0, e:32'hFFFF_FFFF, st:32'h20, dw:24'd2, lp:1'b0, n:2, d:2,
                    w:{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFF0}};
        vecs[3] = '{s:32'h10, e:32'h0, st:32'h20, dw:24'd2, lp:1'b0, n:2, d:2,
                    w:{32'd0, 32'd0, 32'h0, 32'h10}};
        vecs[4] = '{s:32'd17179, e:32'd17179, st:32'd5, dw:24'd3, lp:1'b0, n:1, d:3,
                    w:{32'd0, 32'd0, 32'd0, 32'd17179}};
        vecs[5] = '{s:32'd8590, e:32'd34359, st:32'd0, dw:24'd2, lp:1'b0, n:2, d:2,
                    w:{32'd0, 32'd0, 32'd34359, 32'd8590}};
        vecs[6] = '{s:32'd50, e:32'd20, st:32'd15, dw:24'd1, lp:1'b0, n:3, d:1,
                    w:{32'd0, 32'd20, 32'd35, 32'd50}};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; loop_en = 1'b0;
        fcw_start = '0; fcw_stop = '0; fcw_step = '0; dwell = '0;
        #12;
        chk("reset fcw_out", fcw_out, 32'd0);
        chk("reset valid", {31'b0, fcw_valid}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset tick", {31'b0, step_tick}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle busy", {31'b0, busy}, 32'd0);

        for (int unsigned i = 0; i < 7; i++) run_sweep(i);

        // Looping sweep 0,10,20,0,... then abort while the word is 10.
        fcw_start = 32'd0; fcw_stop = 32'd20; fcw_step = 32'd10; dwell = 24'd2; loop_en = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int unsigned c = 0; c <= 14; c++) begin
            chk($sformatf("loop c%0d fcw_out", c), fcw_out, ((c / 2) % 3) * 10);
            chk($sformatf("loop c%0d step_tick", c), {31'b0, step_tick}, {31'b0, (c % 2) == 0});
            chk($sformatf("loop c%0d done", c), {31'b0, done}, 32'd0);
            if (c < 14) @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            chk($sformatf("abort c%0d busy", c), {31'b0, busy}, 32'd0);
            chk($sformatf("abort c%0d fcw_out", c), fcw_out, 32'd10);
            chk($sformatf("abort c%0d done", c), {31'b0, done}, 32'd0);
            chk($sformatf("abort c%0d tick", c), {31'b0, step_tick}, 32'd0);
            @(negedge clk);
        end

        // abort beats start in IDLE
        drive_cfg(vecs[0]);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("abort+start busy", {31'b0, busy}, 32'd0);
        chk("abort+start fcw_out", fcw_out, 32'd10);
        chk("abort+start tick", {31'b0, step_tick}, 32'd0);
        @(negedge clk);
        run_sweep(0);

        // Asynchronous reset mid-dwell, checked before the next clock edge.
        drive_cfg(vecs[0]);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        chk("pre-reset fcw_out", fcw_out, 32'd110);
        #1 rst_n = 1'b0;
        #1;
        chk("async rst fcw_out", fcw_out, 32'd0);
        chk("async rst valid", {31'b0, fcw_valid}, 32'd0);
        chk("async rst busy", {31'b0, busy}, 32'd0);
        chk("async rst tick", {31'b0, step_tick}, 32'd0);
        chk("async rst done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset busy", {31'b0, busy}, 32'd0);
        chk("post-reset fcw_out", fcw_out, 32'd0);
        run_sweep(0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
